// File: rtl/sudoku_win_checker_if.sv
// Read-only RAM port B link between the win checker and the grid RAM.
interface sudoku_win_checker_if;
  logic [1:0]  RamAddr;
  logic [23:0] RamDat;

  // Checker side: issues row addresses, receives row words
  modport master (output RamAddr, input RamDat);
  // RAM side: receives row addresses, returns row words
  modport slave (input RamAddr, output RamDat);
endinterface

// File: rtl/sudoku_win_checker.sv
// Background 4x4 Sudoku scanner: fetches all rows through RAM port B,
// evaluates row/column/box constraints and drives a registered win flag.
module sudoku_win_checker #(
  parameter int unsigned RAM_LATENCY   = 1,
  parameter int unsigned CONFIRM_SCANS = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  sudoku_win_checker_if.master        ram,
  output logic                        gameComplete,
  output logic                        scanDone
);

  localparam int unsigned CW    = (RAM_LATENCY > 4) ? $clog2(RAM_LATENCY) : 2;
  localparam int unsigned PCW   = 3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    EVAL  = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [1:0]                       addr_q, addr_d;
  logic [PCW-1:0]                   pcnt_q, pcnt_d;
  logic                             win_q, win_d;
  logic                             done_q, done_d;
  logic [RAM_LATENCY-1:0]           dl_vld_q, dl_vld_d;
  logic [RAM_LATENCY-1:0][1:0]      dl_idx_q, dl_idx_d;
  logic [3:0][3:0][3:0]             grid_q, grid_d;
  logic                             fetch_c;
  logic                             pass_c;
  logic [3:0]                       row_oh [4];
  logic [3:0]                       col_oh [4];
  logic [3:0]                       box_oh [4];
  logic                             unused_c;

  // Protect/reserved bits of each cell are not part of the puzzle
  assign unused_c = ^{ram.RamDat[23:22], ram.RamDat[17:16],
                      ram.RamDat[11:10], ram.RamDat[5:4]};

  function automatic logic [3:0] onehot(input logic [3:0] v);
    logic [3:0] o;
    o = '0;
    case (v)
      4'd1:    o = 4'b0001;
      4'd2:    o = 4'b0010;
      4'd3:    o = 4'b0100;
      4'd4:    o = 4'b1000;
      default: o = '0;
    endcase
    return o;
  endfunction

  assign fetch_c = (state_q == FETCH);

  // Delay line tracking which row word arrives on RamDat each cycle
  if (RAM_LATENCY == 1) begin : g_dl_one
    assign dl_vld_d = fetch_c;
    assign dl_idx_d = addr_q;
  end else begin : g_dl_multi
    assign dl_vld_d = {dl_vld_q[RAM_LATENCY-2:0], fetch_c};
    assign dl_idx_d = {dl_idx_q[RAM_LATENCY-2:0], addr_q};
  end

  // Constraint check: OR one-hot digits per group, each must cover 1..4
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      row_oh[i] = '0;
      col_oh[i] = '0;
      box_oh[i] = '0;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row_oh[r] = row_oh[r] | onehot(grid_q[2'(r)][2'(c)]);
        col_oh[c] = col_oh[c] | onehot(grid_q[2'(r)][2'(c)]);
        box_oh[(r / 2) * 2 + (c / 2)] = box_oh[(r / 2) * 2 + (c / 2)]
                                        | onehot(grid_q[2'(r)][2'(c)]);
      end
    end
    pass_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ((row_oh[i] != 4'b1111) || (col_oh[i] != 4'b1111) || (box_oh[i] != 4'b1111)) begin
        pass_c = 1'b0;
      end
    end
  end

  // Scan sequencing, row capture, pass confirmation and output next-values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = 2'd0;
    pcnt_d  = pcnt_q;
    win_d   = win_q;
    done_d  = 1'b0;
    grid_d  = grid_q;

    if (dl_vld_q[RAM_LATENCY-1]) begin
      for (int c = 0; c < 4; c++) begin
        grid_d[dl_idx_q[RAM_LATENCY-1]][2'(c)] = ram.RamDat[6*c +: 4];
      end
    end

    case (state_q)
      FETCH: begin
        if (cnt_q == CW'(3)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          addr_d = addr_q + 2'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(RAM_LATENCY - 1)) begin
          state_d = EVAL;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EVAL: begin
        state_d = FETCH;
        cnt_d   = '0;
        if (pass_c) begin
          pcnt_d = (pcnt_q >= PCW'(CONFIRM_SCANS)) ? PCW'(CONFIRM_SCANS)
                                                   : pcnt_q + PCW'(1);
        end else begin
          pcnt_d = '0;
        end
        win_d = (pcnt_d == PCW'(CONFIRM_SCANS));
      end
      default: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      addr_q   <= 2'd0;
      pcnt_q   <= '0;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
      dl_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pcnt_q   <= pcnt_d;
      win_q    <= win_d;
      done_q   <= done_d;
      dl_vld_q <= dl_vld_d;
    end
  end

  // Row buffer and row-index pipeline; always refilled before use
  always_ff @(posedge CLK) begin
    grid_q   <= grid_d;
    dl_idx_q <= dl_idx_d;
  end

  assign ram.RamAddr  = addr_q;
  assign gameComplete = win_q;
  assign scanDone     = done_q;

endmodule

// File: tb/tb_sudoku_win_checker.sv
// Self-checking bench for sudoku_win_checker: two instances (latency 1 /
// confirm 1 and latency 2 / confirm 2), each with its own synchronous RAM.
module tb_sudoku_win_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sudoku_win_checker_if ifa ();
  sudoku_win_checker_if ifb ();
  logic gc_a, sd_a, gc_b, sd_b;

  sudoku_win_checker #(.RAM_LATENCY(1), .CONFIRM_SCANS(1)) dut_a (
    .CLK(clk), .RST(rst), .ram(ifa), .gameComplete(gc_a), .scanDone(sd_a));
  sudoku_win_checker #(.RAM_LATENCY(2), .CONFIRM_SCANS(2)) dut_b (
    .CLK(clk), .RST(rst), .ram(ifb), .gameComplete(gc_b), .scanDone(sd_b));

  logic [23:0] mem [2][4];
  logic [23:0] q_b1;

  always @(posedge clk) ifa.RamDat <= mem[0][ifa.RamAddr];
  always @(posedge clk) begin
    q_b1       <= mem[1][ifb.RamAddr];
    ifb.RamDat <= q_b1;
  end

  int cur_sel = 0;
  int ph = 0;
  int count_m = 0;
  bit exp_win = 1'b0;
  int vec = 0;
  int miss = 0;
  logic [23:0] snap [4];
  int gd [4][4];
  int sol [4][4] = '{'{1,2,3,4}, '{3,4,1,2}, '{2,1,4,3}, '{4,3,2,1}};

  logic [1:0] addr_s;
  logic gc_s, sd_s;
  always_comb begin
    if (cur_sel == 1) begin
      addr_s = ifb.RamAddr; gc_s = gc_b; sd_s = sd_b;
    end else begin
      addr_s = ifa.RamAddr; gc_s = gc_a; sd_s = sd_a;
    end
  end

  function automatic int per();
    return (cur_sel == 1) ? 7 : 6;
  endfunction

  function automatic int conf();
    return (cur_sel == 1) ? 2 : 1;
  endfunction

  // Reference: every row, column and box holds each digit 1..4 exactly once
  function automatic bit ref_pass();
    int v [4][4];
    int nr, nc, nb;
    bit ok;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[r][c] = int'(snap[r][6*c +: 4]);
    ok = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      for (int i = 0; i < 4; i++) begin
        nr = 0; nc = 0; nb = 0;
        for (int j = 0; j < 4; j++) begin
          if (v[i][j] == d) nr++;
          if (v[j][i] == d) nc++;
          if (v[(i / 2) * 2 + j / 2][(i % 2) * 2 + j % 2] == d) nb++;
        end
        if (nr != 1 || nc != 1 || nb != 1) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic write_mem(input int sel, input bit prot);
    logic [23:0] w;
    for (int r = 0; r < 4; r++) begin
      w = '0;
      for (int c = 0; c < 4; c++) w[6*c +: 6] = {(prot ? 2'b11 : 2'b00), 4'(gd[r][c])};
      mem[sel][r] = w;
    end
  endtask

  task automatic gen_valid();
    int p [4];
    int rm [4];
    int cm [4];
    int j, t, b, s0, s1;
    p = '{1, 2, 3, 4};
    for (int i = 3; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); t = p[i]; p[i] = p[j]; p[j] = t;
    end
    b = int'($urandom % 2); s0 = int'($urandom % 2); s1 = int'($urandom % 2);
    rm = '{2*b + s0, 2*b + 1 - s0, 2*(1-b) + s1, 2*(1-b) + 1 - s1};
    b = int'($urandom % 2); s0 = int'($urandom % 2); s1 = int'($urandom % 2);
    cm = '{2*b + s0, 2*b + 1 - s0, 2*(1-b) + s1, 2*(1-b) + 1 - s1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        gd[r][c] = p[sol[rm[r]][cm[c]] - 1];
  endtask

  // One clock cycle: advance the scan model and check address, pulse, flag
  task automatic step();
    logic [1:0] ea;
    @(negedge clk);
    ph = (ph + 1) % per();
    if (ph == 1) for (int r = 0; r < 4; r++) snap[r] = mem[cur_sel][r];
    if (ph == 0) begin
      if (ref_pass()) count_m = (count_m < conf()) ? count_m + 1 : count_m;
      else count_m = 0;
      exp_win = (count_m == conf());
    end
    ea = (ph < 4) ? 2'(ph) : 2'd0;
    vec++;
    if (addr_s !== ea) begin
      miss++; $display("FAIL addr sel=%0d ph=%0d got=%0d exp=%0d", cur_sel, ph, addr_s, ea);
    end
    vec++;
    if (sd_s !== (ph == per() - 1)) begin
      miss++; $display("FAIL scanDone sel=%0d ph=%0d got=%b exp=%b", cur_sel, ph, sd_s, (ph == per() - 1));
    end
    vec++;
    if (gc_s !== exp_win) begin
      miss++; $display("FAIL gameComplete sel=%0d ph=%0d got=%b exp=%b", cur_sel, ph, gc_s, exp_win);
    end
  endtask

  task automatic run(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (ph == 0) k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vec += 3;
      if (addr_s !== 2'd0) begin miss++; $display("FAIL rst_addr got=%0d exp=0", addr_s); end
      if (sd_s !== 1'b0) begin miss++; $display("FAIL rst_scanDone got=%b exp=0", sd_s); end
      if (gc_s !== 1'b0) begin miss++; $display("FAIL rst_gameComplete got=%b exp=0", gc_s); end
    end
    rst = 1'b0;
    ph = 0; count_m = 0; exp_win = 1'b0;
  endtask

  task automatic test_reset();
    cur_sel = 0;
    gd = sol; write_mem(0, 1'b0); write_mem(1, 1'b0);
    do_reset();
    run(2);
    vec++;
    if (gc_s !== 1'b1) begin miss++; $display("FAIL reset_prewin got=%b exp=1", gc_s); end
    repeat (2) step();
    do_reset();
    run(1);
    vec++;
    if (gc_s !== 1'b1) begin miss++; $display("FAIL reset_postwin got=%b exp=1", gc_s); end
  endtask

  task automatic test_solved();
    cur_sel = 0;
    gd = sol; write_mem(0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run(1);
      vec++;
      if (gc_s !== 1'b1) begin miss++; $display("FAIL solved scan=%0d got=%b exp=1", i, gc_s); end
    end
  endtask

  task automatic test_protect();
    cur_sel = 0;
    gd = sol; write_mem(0, 1'b1);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run(1);
      vec++;
      if (gc_s !== 1'b1) begin miss++; $display("FAIL protect scan=%0d got=%b exp=1", i, gc_s); end
    end
  endtask

  task automatic test_negative();
    cur_sel = 0;
    for (int k = 0; k < 4; k++) begin
      gd = sol; write_mem(0, 1'b0);
      run(1);
      vec++;
      if (gc_s !== 1'b1) begin miss++; $display("FAIL neg_pre case=%0d got=%b exp=1", k, gc_s); end
      gd = sol;
      case (k)
        0: gd[1][2] = 0;
        1: gd[3][0] = 7;
        2: for (int r = 0; r < 4; r++) gd[r] = '{1, 2, 3, 4};
        default: gd = '{'{1,2,3,4}, '{2,1,4,3}, '{3,4,1,2}, '{4,3,2,1}};
      endcase
      write_mem(0, 1'b0);
      run(1);
      vec++;
      if (gc_s !== 1'b0) begin miss++; $display("FAIL neg case=%0d got=%b exp=0", k, gc_s); end
    end
  endtask

  task automatic test_live_edit();
    cur_sel = 0;
    gd = sol; write_mem(0, 1'b0);
    run(1);
    vec++;
    if (gc_s !== 1'b1) begin miss++; $display("FAIL live_pre got=%b exp=1", gc_s); end
    repeat (3) step();
    gd[2][1] = 0; write_mem(0, 1'b0);
    run(1);
    vec++;
    if (gc_s !== 1'b1) begin miss++; $display("FAIL live_late_edit got=%b exp=1", gc_s); end
    run(1);
    vec++;
    if (gc_s !== 1'b0) begin miss++; $display("FAIL live_edit got=%b exp=0", gc_s); end
    gd = sol; write_mem(0, 1'b0);
    run(1);
    vec++;
    if (gc_s !== 1'b1) begin miss++; $display("FAIL live_restore got=%b exp=1", gc_s); end
  endtask

  task automatic test_confirm();
    bit exp_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    cur_sel = 1;
    gd = sol; write_mem(1, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      gd = sol;
      if (i == 4) gd[0][0] = 7;
      write_mem(1, 1'b0);
      run(1);
      vec++;
      if (gc_s !== exp_seq[i]) begin
        miss++; $display("FAIL confirm scan=%0d got=%b exp=%b", i, gc_s, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    int r, c, t;
    for (int sel = 0; sel < 2; sel++) begin
      cur_sel = sel;
      gd = sol; write_mem(sel, 1'b0);
      do_reset();
      for (int i = 0; i < 25; i++) begin
        gen_valid();
        case ($urandom % 4)
          0: begin
            r = int'($urandom % 4); c = int'($urandom % 4);
            gd[r][c] = int'($urandom % 16);
          end
          1: begin
            r = int'($urandom % 4);
            t = gd[r][0]; gd[r][0] = gd[r][3]; gd[r][3] = t;
          end
          default: ;
        endcase
        write_mem(sel, bit'($urandom % 2));
        run(1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_solved();
    test_protect();
    test_negative();
    test_live_edit();
    test_confirm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sudoku_win_checker.md
Name: sudoku_win_checker

Overview:
Background scanner that reads the 4x4 Sudoku grid through the RAM's read-only port B. It evaluates the row, column and 2x2-box constraints and drives the win indicator. It replaces the checker in the top level and uses the same connections: RamAddr, RamDat, gameComplete, CLK, RST. It loops forever, so the indicator tracks edits made by the interface controller through port A.

Parameters:
RAM_LATENCY, 1, cycles from RamAddr presentation to valid RamDat (>=1)
CONFIRM_SCANS, 1, consecutive passing scans required before gameComplete asserts (1..7)

Ports:
CLK  input  1  system clock; the block uses this single clock
RST  input  1  synchronous, active-high reset
RamAddr  output  2  row address to RAM port B
RamDat  input  24  row data from RAM port B (q_b)
gameComplete  output  1  win indicator; registered
scanDone  output  1  one-cycle pulse when a scan's evaluation completes; debug, may be left open

Behaviour:
- Row word format: cell c (0..3, column c) occupies RamDat[6c+5:6c].
  - Value field is [6c+3:6c].
  - Bits [6c+5:6c+4] (protect/reserved) are ignored by this block.
- Value 0 means an empty cell. Values 5..15 are illegal.
- FSM states: FETCH, DRAIN, EVAL.
  - FETCH: 4 cycles; RamAddr = 0,1,2,3 in successive cycles.
  - DRAIN: RAM_LATENCY cycles; RamAddr = 0.
  - EVAL: 1 cycle; RamAddr = 0. Returns to FETCH with address 0.
- Scan period = 5 + RAM_LATENCY cycles (6 at default).
- Capture: the row issued in scan cycle k is sampled into row buffer k at the end of cycle k+RAM_LATENCY.
  - A delay line of length RAM_LATENCY carries a valid bit plus the 2-bit row index.
  - The last capture lands at the end of the final DRAIN cycle.
- EVAL computes pass from the buffer. pass = 1 iff all of the following hold:
  - all 16 values are in 1..4;
  - every row holds each of 1..4 exactly once;
  - every column holds each of 1..4 exactly once;
  - every box holds each of 1..4 exactly once. Boxes are rows {0,1}/{2,3} x columns {0,1}/{2,3}.
- Checking method: OR one-hot decodes across each group of 4 and compare with 4'b1111.
- Pass counter (3-bit), updated at the end of EVAL:
  - pass -> count = min(count+1, CONFIRM_SCANS);
  - fail -> count = 0.
- gameComplete is registered at the end of EVAL as (count_next == CONFIRM_SCANS). It changes only then.
- scanDone is high for exactly the EVAL cycle.
- Concurrent writes through port A during a scan may yield a mixed snapshot. No special handling is required; the next scan corrects the result.
- Reset, including assertion mid-scan:
  - state = FETCH, RamAddr = 0, gameComplete = 0, scanDone = 0, pass counter = 0;
  - delay-line valid bits cleared, so no stale capture survives.
  - Row buffer contents are don't-care, because a full scan always overwrites them before EVAL.
  - The first cycle after RST deasserts issues address 0.
- No combinational path from RamDat to any output.

Test Plan:
1. Reset values: assert RST 3 cycles, including mid-scan -> gameComplete=0, scanDone=0, RamAddr=0; first post-reset cycle has RamAddr=0, and the sequence 0,1,2,3,0,0 repeats with period 6.
2. Solved grid, RAM_LATENCY=1:
   - row values: 1234, 3412, 2143, 4321;
   - row 0 word = 24'h103081;
   - RAM is a 1-cycle synchronous model;
   - required: scanDone pulses in cycle 5 after reset release; gameComplete rises at the end of that cycle and stays 1 across 10 scans.
3. Same grid with all protect bits [6c+4] and bits [6c+5] set -> gameComplete=1 (ignored bits).
4. Negative grids, each giving gameComplete=0 after the first EVAL:
   - one cell set to 0;
   - one cell set to 7;
   - all rows 1234 (rows pass, columns fail);
   - rows 1234, 2143, 3412, 4321 (rows and columns pass, box fails).
5. Live edit: solved grid, gameComplete=1; overwrite cell (2,1) with 0 -> gameComplete falls at the end of the first EVAL whose scan sampled the edit. Restore the cell -> gameComplete returns to 1 within 2 scan periods.
6. CONFIRM_SCANS=2, RAM_LATENCY=2 -> period 7 cycles; gameComplete rises only at the end of the second passing EVAL. A single failing scan drops it to 0 and restarts confirmation.
